// File: rtl/proc16_mem_pkg.sv
// proc16_mem_pkg: shared definitions for the 16-bit core's unified-memory arbiter.
//   - arb_state_t : arbiter FSM state encoding (2-bit)
//   - REQ_CORE / REQ_DBG : requester IDs, also used as the owner/last_grant encoding
//   - DEF_AW / DEF_DW : default address and data widths
package proc16_mem_pkg;

   localparam int unsigned DEF_AW = 16;
   localparam int unsigned DEF_DW = 16;

   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_DBG  = 1'b1;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StWait   = 2'd2,
      StResp   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_arb_sel.sv
// mem_arb_sel: combinational winner select between the core and debug requesters.
// Build option: ARB_RR_EN defined   -> round-robin on a tie (grant the one not granted last).
//               ARB_RR_EN undefined -> fixed priority, the core wins every tie.
// Ports:
//   core_req, dbg_req : request inputs
//   last_grant        : requester granted most recently (REQ_CORE / REQ_DBG)
//   any_req           : at least one request is pending
//   winner            : selected requester ID, meaningful only when any_req is high
module mem_arb_sel
   import proc16_mem_pkg::*;
(
   input  logic core_req,
   input  logic dbg_req,
   input  logic last_grant,
   output logic any_req,
   output logic winner
);

`ifndef ARB_RR_EN
   // Fixed priority ignores the grant history.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   always_comb begin
      any_req = core_req | dbg_req;
      winner  = REQ_CORE;
      if (core_req && dbg_req) begin
`ifdef ARB_RR_EN
         winner = (last_grant == REQ_CORE) ? REQ_DBG : REQ_CORE;
`else
         winner = REQ_CORE;
`endif
      end else if (dbg_req) begin
         winner = REQ_DBG;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported unified memory between the core and the
// debug/program-loader port. One access at a time: IDLE -> ACCESS -> WAIT x WAIT_STATES ->
// RESP -> IDLE. Requests are only sampled in IDLE; request fields are latched at grant.
// Build option: ARB_RR_EN selects round-robin tie-break (see mem_arb_sel), else core priority.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   core_req/we/addr/wdata, core_ack : core requester, ack is a one-cycle pulse
//   dbg_req/we/addr/wdata,  dbg_ack  : debug requester, ack is a one-cycle pulse
//   rdata                            : data of the last completed read, held until next read
//   busy                             : high whenever the FSM is not idle
//   owner                            : current/last grantee (0 = core, 1 = dbg)
//   mem_addr/wdata/re/we, mem_rdata  : memory side; re/we strobe for the ACCESS cycle only
module mem_port_arbiter
   import proc16_mem_pkg::*;
#(
   parameter int unsigned AW          = DEF_AW,
   parameter int unsigned DW          = DEF_DW,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned CNT_W       = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_ack,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          owner,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_re,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q;
   logic             owner_q;
   logic             last_grant_q;
   logic [AW-1:0]    addr_q;
   logic [DW-1:0]    wdata_q;
   logic [DW-1:0]    rdata_q;

   logic             any_req;
   logic             winner;
   logic             grant;
   logic             capture;

   mem_arb_sel u_sel (
      .core_req   (core_req),
      .dbg_req    (dbg_req),
      .last_grant (last_grant_q),
      .any_req    (any_req),
      .winner     (winner)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant   = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               grant   = 1'b1;
               state_d = StAccess;
            end
         end
         StAccess: begin
            cnt_d = CNT_W'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
               // Zero-wait memory returns data in the strobe cycle itself.
               capture = ~we_q;
               state_d = StResp;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               capture = ~we_q;
               state_d = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         owner_q      <= REQ_CORE;
         last_grant_q <= REQ_DBG;   // core wins the first tie
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (grant) begin
            owner_q      <= winner;
            last_grant_q <= winner;
            we_q         <= (winner == REQ_DBG) ? dbg_we : core_we;
            addr_q       <= (winner == REQ_DBG) ? dbg_addr : core_addr;
            wdata_q      <= (winner == REQ_DBG) ? dbg_wdata : core_wdata;
         end
         if (capture) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_re    = (state_q == StAccess) && !we_q;
      mem_we    = (state_q == StAccess) && we_q;
      core_ack  = (state_q == StResp) && (owner_q == REQ_CORE);
      dbg_ack   = (state_q == StResp) && (owner_q == REQ_DBG);
      busy      = (state_q != StIdle);
      owner     = owner_q;
      rdata     = rdata_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Three instances: WAIT_STATES = 1 (main), 0 and 15.
// The memory model only presents valid data exactly WAIT_STATES cycles after the mem_re cycle,
// and 16'hDEAD at all other times.
module tb_mem_port_arbiter;

   logic clk;
   logic rst;

   logic        core_req   [3];
   logic        core_we    [3];
   logic [15:0] core_addr  [3];
   logic [15:0] core_wdata [3];
   logic        core_ack   [3];
   logic        dbg_req    [3];
   logic        dbg_we     [3];
   logic [15:0] dbg_addr   [3];
   logic [15:0] dbg_wdata  [3];
   logic        dbg_ack    [3];
   logic [15:0] rdata      [3];
   logic        busy       [3];
   logic        owner      [3];
   logic [15:0] mem_addr   [3];
   logic [15:0] mem_wdata  [3];
   logic        mem_re     [3];
   logic        mem_we     [3];
   logic [15:0] mem_rdata  [3];

   logic [15:0] mem [256];

   int re_cnt   [3] = '{0, 0, 0};
   int we_cnt   [3] = '{0, 0, 0};
   int both_ack = 0;

   int err_cnt = 0;
   int chk_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned WS = (g == 0) ? 1 : (g == 1) ? 0 : 15;
      logic [4:0] age = 5'd0;
      logic       valid;

      mem_port_arbiter #(
         .AW          (16),
         .DW          (16),
         .WAIT_STATES (WS),
         .CNT_W       (4)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .core_req   (core_req[g]),
         .core_we    (core_we[g]),
         .core_addr  (core_addr[g]),
         .core_wdata (core_wdata[g]),
         .core_ack   (core_ack[g]),
         .dbg_req    (dbg_req[g]),
         .dbg_we     (dbg_we[g]),
         .dbg_addr   (dbg_addr[g]),
         .dbg_wdata  (dbg_wdata[g]),
         .dbg_ack    (dbg_ack[g]),
         .rdata      (rdata[g]),
         .busy       (busy[g]),
         .owner      (owner[g]),
         .mem_addr   (mem_addr[g]),
         .mem_wdata  (mem_wdata[g]),
         .mem_re     (mem_re[g]),
         .mem_we     (mem_we[g]),
         .mem_rdata  (mem_rdata[g])
      );

      always @(posedge clk) begin
         if (mem_re[g]) age <= 5'd1;
         else if (age != 5'd0 && age < 5'd20) age <= age + 5'd1;
         else age <= 5'd0;
      end

      assign valid = (WS == 0) ? mem_re[g] : (age == 5'(WS));
      assign mem_rdata[g] = valid ? mem[mem_addr[g][7:0]] : 16'hDEAD;
   end

   // Only the main instance is ever asked to write.
   always @(posedge clk) begin
      if (mem_we[0]) mem[mem_addr[0][7:0]] = mem_wdata[0];
      for (int k = 0; k < 3; k++) begin
         if (mem_re[k]) re_cnt[k]++;
         if (mem_we[k]) we_cnt[k]++;
         if (core_ack[k] && dbg_ack[k]) both_ack++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input int i, input bit dbg, input bit we, input logic [15:0] a,
                        input logic [15:0] d);
      if (dbg) begin
         dbg_req[i] = 1'b1; dbg_we[i] = we; dbg_addr[i] = a; dbg_wdata[i] = d;
      end else begin
         core_req[i] = 1'b1; core_we[i] = we; core_addr[i] = a; core_wdata[i] = d;
      end
   endtask

   // Counts negedges until an ack is seen; cyc = -1 when the bound expires.
   task automatic wait_ack(input int i, input int limit, output int cyc, output bit who,
                           output int busy_lo);
      cyc = 0; who = 1'b0; busy_lo = 0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         cyc++;
         if (k > 0 && !busy[i]) busy_lo++;
         if (core_ack[i] || dbg_ack[i]) begin
            who = dbg_ack[i];
            return;
         end
      end
      cyc = -1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, busy_lo, r0, w0;
      bit who;
      logic [3:0] exp_order;

      for (int k = 0; k < 256; k++) mem[k] = 16'h0;
      mem[8'h01] = 16'h1111;
      mem[8'h02] = 16'h2222;
      mem[8'h10] = 16'hBEEF;
      mem[8'h30] = 16'h5555;
      mem[8'h40] = 16'hA5A5;
      for (int k = 0; k < 3; k++) begin
         core_req[k] = 0; core_we[k] = 0; core_addr[k] = '0; core_wdata[k] = '0;
         dbg_req[k] = 0; dbg_we[k] = 0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy[0], 0);
      check("rst_owner", owner[0], 0);
      check("rst_rdata", rdata[0], 0);
      check("rst_mem_addr", mem_addr[0], 0);
      check("rst_strobes", {mem_re[0], mem_we[0]}, 0);
      check("rst_acks", {core_ack[0], dbg_ack[0]}, 0);
      @(posedge clk); #1 rst = 1'b0;

      // 1: core read, WAIT_STATES=1
      @(posedge clk); #1;
      r0 = re_cnt[0];
      issue(0, 0, 0, 16'h0010, 16'h0);
      @(negedge clk); check("t1_idle_busy", busy[0], 0);
      @(negedge clk);
      check("t1_re", mem_re[0], 1);
      check("t1_addr", mem_addr[0], 16'h0010);
      check("t1_busy", busy[0], 1);
      @(negedge clk);
      check("t1_re_low", mem_re[0], 0);
      check("t1_no_early_ack", core_ack[0], 0);
      @(negedge clk);
      check("t1_ack", core_ack[0], 1);
      check("t1_rdata", rdata[0], 16'hBEEF);
      check("t1_re_pulses", re_cnt[0] - r0, 1);
      core_req[0] = 1'b0;

      // 2: debug write
      @(posedge clk); #1;
      w0 = we_cnt[0];
      issue(0, 1, 1, 16'h0020, 16'h1234);
      @(negedge clk);
      @(negedge clk);
      check("t2_we", mem_we[0], 1);
      check("t2_re", mem_re[0], 0);
      check("t2_addr", mem_addr[0], 16'h0020);
      check("t2_wdata", mem_wdata[0], 16'h1234);
      wait_ack(0, 10, cyc, who, busy_lo);
      check("t2_lat", cyc, 2);
      check("t2_who", who, 1);
      check("t2_owner", owner[0], 1);
      check("t2_rdata_kept", rdata[0], 16'hBEEF);
      check("t2_we_pulses", we_cnt[0] - w0, 1);
      check("t2_mem", mem[8'h20], 16'h1234);
      dbg_req[0] = 1'b0; dbg_we[0] = 1'b0;

      // 3: tie, both held for four grants
`ifdef ARB_RR_EN
      exp_order = 4'b1010;
`else
      exp_order = 4'b0000;
`endif
      @(posedge clk); #1;
      issue(0, 0, 0, 16'h0001, 16'h0);
      issue(0, 1, 0, 16'h0002, 16'h0);
      for (int g = 0; g < 4; g++) begin
         wait_ack(0, 20, cyc, who, busy_lo);
         check($sformatf("t3_lat%0d", g), cyc, 4);
         check($sformatf("t3_who%0d", g), who, exp_order[g]);
         check($sformatf("t3_owner%0d", g), owner[0], exp_order[g]);
         check($sformatf("t3_addr%0d", g), mem_addr[0], exp_order[g] ? 16'h0002 : 16'h0001);
         check($sformatf("t3_rdata%0d", g), rdata[0], exp_order[g] ? 16'h2222 : 16'h1111);
      end
      core_req[0] = 1'b0; dbg_req[0] = 1'b0;

      // 6: request fields changed after grant have no effect
      @(posedge clk); #1;
      w0 = we_cnt[0];
      issue(0, 0, 0, 16'h0010, 16'h0);
      @(negedge clk);
      @(negedge clk);
      check("t6_re", mem_re[0], 1);
      core_addr[0] = 16'h0030; core_we[0] = 1'b1; core_wdata[0] = 16'hFFFF;
      @(negedge clk);
      check("t6_addr_hold", mem_addr[0], 16'h0010);
      wait_ack(0, 10, cyc, who, busy_lo);
      check("t6_lat", cyc, 1);
      check("t6_who", who, 0);
      check("t6_addr_resp", mem_addr[0], 16'h0010);
      check("t6_rdata", rdata[0], 16'hBEEF);
      check("t6_no_write", we_cnt[0] - w0, 0);
      core_req[0] = 1'b0; core_we[0] = 1'b0;

      // 5: reset during WAIT of a core read
      @(posedge clk); #1;
      issue(0, 0, 0, 16'h0030, 16'h0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("t5_in_wait", busy[0], 1);
      rst = 1'b1;
      @(negedge clk);
      check("t5_busy", busy[0], 0);
      check("t5_re", mem_re[0], 0);
      check("t5_ack", core_ack[0], 0);
      check("t5_rdata", rdata[0], 0);
      rst = 1'b0; core_req[0] = 1'b0;
      wait_ack(0, 8, cyc, who, busy_lo);
      check("t5_no_ack", cyc, -1);

      // 4: WAIT_STATES = 0 and 15
      @(posedge clk); #1;
      issue(1, 0, 0, 16'h0040, 16'h0);
      wait_ack(1, 30, cyc, who, busy_lo);
      check("t4_ws0_lat", cyc, 3);
      check("t4_ws0_rdata", rdata[1], 16'hA5A5);
      check("t4_ws0_busy", busy_lo, 0);
      core_req[1] = 1'b0;
      @(negedge clk); check("t4_ws0_idle", busy[1], 0);
      @(posedge clk); #1;
      issue(2, 0, 0, 16'h0040, 16'h0);
      wait_ack(2, 30, cyc, who, busy_lo);
      check("t4_ws15_lat", cyc, 18);
      check("t4_ws15_rdata", rdata[2], 16'hA5A5);
      check("t4_ws15_busy", busy_lo, 0);
      core_req[2] = 1'b0;
      @(negedge clk); check("t4_ws15_idle", busy[2], 0);

      check("both_acks", both_ack, 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
